// File: rtl/seq_subtractor_32_bit_if.sv
// Handshake and data bundle for the multi-cycle subtractor.
// Requester drives start/a/b/bin; subtractor returns busy/done and the result.
// Ports: start, a, b, bin (request); busy, done, diff, bout, zero, ovf (response).
interface seq_subtractor_32_bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    // Requester side.
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
endinterface

// File: rtl/seq_subtractor_32_bit.sv
// Multi-cycle subtractor: a - b - bin, one CHUNK-bit slice per clock, with borrow/zero/ovf flags.
// Latency: NCHUNK cycles from the accepting edge to the one-cycle done pulse; all outputs registered.
// Backpressure: start is ignored while busy; it is re-accepted in the done cycle (one op per NCHUNK+1).
// Ports: clk, rst (sync, active high), bus (slave modport: start/a/b/bin in; busy/done/diff/bout/zero/ovf out).
module seq_subtractor_32_bit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_subtractor_32_bit_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;      // running carry; carry = NOT borrow
    logic [IDXW-1:0]  idx;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             zero_r;
    logic             ovf_r;

    // Current slice and the diff as it will look after this edge.
    int               base;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] diff_nx;
    logic             last;

    always_comb begin
        base    = int'(idx) * CHUNK;
        // Subtraction as a + ~b + carry, where the initial carry is ~bin.
        sum     = {1'b0, a_r[base +: CHUNK]} + {1'b0, ~b_r[base +: CHUNK]}
                + {{CHUNK{1'b0}}, c_r};
        diff_nx = diff_r;
        diff_nx[base +: CHUNK] = sum[CHUNK-1:0];
        last    = (idx == IDXW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= 1'b0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        c_r    <= ~bus.bin;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    diff_r <= diff_nx;
                    c_r    <= sum[CHUNK];
                    if (last) begin
                        // Flags come from the completed result, including this slice.
                        idx    <= '0;
                        bout_r <= ~sum[CHUNK];
                        zero_r <= (diff_nx == '0);
                        ovf_r  <= (a_r[MSB] != b_r[MSB]) && (diff_nx[MSB] != a_r[MSB]);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_subtractor_32_bit.sv
// Directed bench for seq_subtractor_32_bit with hand-computed expected results.
module tb_seq_subtractor_32_bit;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;

    seq_subtractor_32_bit_if #(.WIDTH(32)) bus ();

    seq_subtractor_32_bit #(.WIDTH(32), .CHUNK(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable when this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; lat = edges from accept to done, 99 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin, output int l);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.start = 1'b1;
        step();
        chk("accept_busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        l = 99;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (bus.done) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", bus.diff, 32'd0);
        chk("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);

        // Basic 5 - 3, with cycle-by-cycle handshake
        bus.a = 32'd5; bus.b = 32'd3; bus.bin = 1'b0; bus.start = 1'b1;
        step();
        chk("basic_e0_busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        step();
        chk("basic_e1_busy", {31'd0, bus.busy}, 32'd1);
        chk("basic_e1_done", {31'd0, bus.done}, 32'd0);
        step();
        chk("basic_e2_done", {31'd0, bus.done}, 32'd1);
        chk("basic_e2_busy", {31'd0, bus.busy}, 32'd0);
        chk("basic_diff", bus.diff, 32'h0000_0002);
        chk("basic_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b000);
        step();
        chk("basic_done_pulse", {31'd0, bus.done}, 32'd0);

        // 0 - 1 underflow
        run_op(32'd0, 32'd1, 1'b0, lat);
        chk("uf_lat", lat, 32'd2);
        chk("uf_diff", bus.diff, 32'hFFFF_FFFF);
        chk("uf_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b100);

        // 7 - 7 - 1 via borrow-in
        run_op(32'd7, 32'd7, 1'b1, lat);
        chk("bin_lat", lat, 32'd2);
        chk("bin_diff", bus.diff, 32'hFFFF_FFFF);
        chk("bin_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b100);

        // Borrow across the chunk boundary
        run_op(32'h0001_0000, 32'h0000_0001, 1'b0, lat);
        chk("xchunk_lat", lat, 32'd2);
        chk("xchunk_diff", bus.diff, 32'h0000_FFFF);
        chk("xchunk_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b000);

        // Signed overflow: most negative minus one
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        chk("ovf_lat", lat, 32'd2);
        chk("ovf_diff", bus.diff, 32'h7FFF_FFFF);
        chk("ovf_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b001);

        // Zero result, then hold for 5 idle cycles
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, lat);
        chk("zero_lat", lat, 32'd2);
        chk("zero_diff", bus.diff, 32'd0);
        chk("zero_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b010);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_diff", bus.diff, 32'd0);
            chk("hold_zero", {31'd0, bus.zero}, 32'd1);
            chk("hold_ctl", {30'd0, bus.busy, bus.done}, 32'b00);
        end

        // start pulsed during RUN is ignored
        bus.a = 32'd100; bus.b = 32'd1; bus.bin = 1'b0; bus.start = 1'b1;
        step();
        bus.a = 32'd50; bus.b = 32'd20; bus.bin = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_e1_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("ign_done", {31'd0, bus.done}, 32'd1);
        chk("ign_diff", bus.diff, 32'd99);
        step();
        chk("ign_no_restart", {30'd0, bus.busy, bus.done}, 32'b00);

        // start held high: 10 - 4 completes every 3 cycles
        bus.a = 32'd10; bus.b = 32'd4; bus.bin = 1'b0; bus.start = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("b2b_done", {31'd0, bus.done}, (i % 3 == 2) ? 32'd1 : 32'd0);
            chk("b2b_busy", {31'd0, bus.busy}, (i % 3 == 2) ? 32'd0 : 32'd1);
            if (i % 3 == 2) chk("b2b_diff", bus.diff, 32'd6);
        end
        bus.start = 1'b0;
        step();
        chk("b2b_release", {30'd0, bus.busy, bus.done}, 32'b00);

        // Reset asserted on E1 aborts the operation
        bus.a = 32'hFFFF_0000; bus.b = 32'd1; bus.bin = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ctl", {30'd0, bus.busy, bus.done}, 32'b00);
        chk("abort_diff", bus.diff, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", {30'd0, bus.busy, bus.done}, 32'b00);
        end
        run_op(32'd5, 32'd3, 1'b0, lat);
        chk("after_rst_lat", lat, 32'd2);
        chk("after_rst_diff", bus.diff, 32'd2);
        chk("after_rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
